// File: rtl/alu_arb_pkg.sv
// Shared types, widths and helpers for the ALU arbiter slice.
package alu_arb_pkg;

  localparam int ALU_CTRL_W    = 2;
  localparam int STAT_W        = 16;
  localparam int ALU_ARB_DEF_W = 32;

  typedef struct packed {
    logic valid;
    logic id;
  } alu_arb_tag_t;

  typedef struct packed {
    logic                     id;
    logic [ALU_ARB_DEF_W-1:0] r;
    logic                     zero;
    logic                     ovf;
    logic                     branch;
  } alu_arb_rsp_t;

  function automatic logic [STAT_W-1:0] statSatInc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/alu_arb_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head data reads as zero when empty.
module alu_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_pushData,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [DW-1:0]          o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPop;

  assign w_doPop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({i_push, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the count is zero.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rdPtr] : '0;
  assign o_count = r_count;

  assert property (@(posedge clk) disable iff (!reset)
    !(i_push && (r_count == CNT_W'(DEPTH)) && !i_pop));

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a credit-protected response FIFO.
// Define ALU_ARB_STATS_EN to build the saturating per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [WIDTH-1:0]      rq0_a,
  input  logic [WIDTH-1:0]      rq0_b,
  input  logic [WIDTH-1:0]      rq1_a,
  input  logic [WIDTH-1:0]      rq1_b,
  input  logic [ALU_CTRL_W-1:0] rq0_ctrl,
  input  logic [ALU_CTRL_W-1:0] rq1_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      alu_r,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  input  logic                  alu_branch,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_zero,
  output logic                  rsp_ovf,
  output logic                  rsp_branch,
  input  logic                  stat_clr,
  output logic [STAT_W-1:0]     stat_gnt0,
  output logic [STAT_W-1:0]     stat_gnt1
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int RSP_W = WIDTH + 4;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_acceptId;
  logic                  w_canIssue;
  logic                  r_rrPrio;
  logic [WIDTH-1:0]      r_aluA;
  logic [WIDTH-1:0]      r_aluB;
  logic [ALU_CTRL_W-1:0] r_aluCtrl;
  alu_arb_tag_t          r_tag [ALU_LAT];
  logic [CNT_W-1:0]      w_fifoCount;
  logic [SUM_W-1:0]      w_inflight;
  logic [SUM_W-1:0]      w_used;
  logic                  w_push;
  logic                  w_pop;
  logic [RSP_W-1:0]      w_pushData;
  logic [RSP_W-1:0]      w_headData;
  logic                  w_headValid;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_tag[i].valid);
    end
  end

  // Every in-flight op already owns a FIFO slot, so overflow is impossible.
  assign w_used     = SUM_W'(w_fifoCount) + w_inflight;
  assign w_canIssue = (w_used < SUM_W'(FIFO_DEPTH));

  always_comb begin
    w_grant = 2'b00;
    if (reset && w_canIssue) begin
      case (rq_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rrPrio ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign rq_ready   = w_grant;
  assign w_accept   = |(rq_valid & w_grant);
  assign w_acceptId = w_grant[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aluA    <= '0;
      r_aluB    <= '0;
      r_aluCtrl <= '0;
      r_rrPrio  <= 1'b0;
      for (int i = 0; i < ALU_LAT; i++) r_tag[i] <= '0;
    end else begin
      if (w_accept) begin
        r_aluA    <= w_acceptId ? rq1_a : rq0_a;
        r_aluB    <= w_acceptId ? rq1_b : rq0_b;
        r_aluCtrl <= w_acceptId ? rq1_ctrl : rq0_ctrl;
        r_rrPrio  <= ~w_acceptId;
      end
      r_tag[0] <= '{valid: w_accept, id: w_acceptId};
      for (int i = 1; i < ALU_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign alu_a    = r_aluA;
  assign alu_b    = r_aluB;
  assign alu_ctrl = r_aluCtrl;

  assign w_push     = r_tag[ALU_LAT-1].valid;
  assign w_pushData = {r_tag[ALU_LAT-1].id, alu_r, alu_zero, alu_ovf, alu_branch};
  assign w_pop      = w_headValid & rsp_ready;

  alu_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (RSP_W)
  ) u_rspFifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_valid    (w_headValid),
    .o_data     (w_headData),
    .o_count    (w_fifoCount)
  );

  assign rsp_valid  = w_headValid;
  assign rsp_id     = w_headData[RSP_W-1];
  assign rsp_r      = w_headData[WIDTH+2:3];
  assign rsp_zero   = w_headData[2];
  assign rsp_ovf    = w_headData[1];
  assign rsp_branch = w_headData[0];

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] r_statGnt0;
  logic [STAT_W-1:0] r_statGnt1;

  // Clear wins over a same-cycle grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_statGnt0 <= '0;
      r_statGnt1 <= '0;
    end else if (stat_clr) begin
      r_statGnt0 <= '0;
      r_statGnt1 <= '0;
    end else if (w_accept) begin
      if (w_acceptId) r_statGnt1 <= statSatInc(r_statGnt1);
      else            r_statGnt0 <= statSatInc(r_statGnt0);
    end
  end

  assign stat_gnt0 = r_statGnt0;
  assign stat_gnt1 = r_statGnt1;
`else
  logic w_unusedStatClr;
  assign w_unusedStatClr = stat_clr;
  assign stat_gnt0       = '0;
  assign stat_gnt1       = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a combinational add-only ALU stub (ALU_LAT = 1).
module tb_alu_arbiter;

  localparam int WIDTH      = 32;
  localparam int ALU_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

`ifdef ALU_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             ovf;
    logic             branch;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [1:0]       rq_valid;
  logic [1:0]       rq_ready;
  logic [WIDTH-1:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic [1:0]       rq0_ctrl, rq1_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [1:0]       alu_ctrl;
  logic             alu_zero, alu_ovf, alu_branch;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_zero, rsp_ovf, rsp_branch;
  logic             stat_clr;
  logic [15:0]      stat_gnt0, stat_gnt1;

  exp_t scoreQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  bit   modelPrio   = 1'b0;

  alu_arbiter #(
    .WIDTH      (WIDTH),
    .ALU_LAT    (ALU_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rq_valid   (rq_valid),
    .rq_ready   (rq_ready),
    .rq0_a      (rq0_a),
    .rq0_b      (rq0_b),
    .rq1_a      (rq1_a),
    .rq1_b      (rq1_b),
    .rq0_ctrl   (rq0_ctrl),
    .rq1_ctrl   (rq1_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero),
    .alu_ovf    (alu_ovf),
    .alu_branch (alu_branch),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .rsp_branch (rsp_branch),
    .stat_clr   (stat_clr),
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1)
  );

  // With ALU_LAT = 1 the registered alu_* inputs are the only pipeline stage.
  assign alu_r      = alu_a + alu_b;
  assign alu_zero   = (alu_r == '0);
  assign alu_ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
  assign alu_branch = alu_zero;

  always #5 clk = ~clk;

  function automatic exp_t calc(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] s;
    s        = a + b;
    e.id     = id;
    e.r      = s;
    e.zero   = (s == '0);
    e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    e.branch = e.zero;
    return e;
  endfunction

  // Response monitor: samples just before the rising edge on which a pop happens.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset && rsp_valid && rsp_ready) begin
        testsRun++;
        if (scoreQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d r=%h, none expected", rsp_id, rsp_r);
        end else begin
          e = scoreQ.pop_front();
          if ({rsp_id, rsp_r, rsp_zero, rsp_ovf, rsp_branch} !== e) begin
            testsFailed++;
            $display("[TB] FAIL rsp: got id=%0d r=%h z=%b o=%b br=%b, expected id=%0d r=%h z=%b o=%b br=%b",
                     rsp_id, rsp_r, rsp_zero, rsp_ovf, rsp_branch, e.id, e.r, e.zero, e.ovf, e.branch);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] expGnt, input logic rdy,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    @(negedge clk);
    #1;
    rq_valid  = v;
    rsp_ready = rdy;
    rq0_a = a0; rq0_b = b0; rq1_a = a1; rq1_b = b1;
    #1;
    testsRun++;
    if (rq_ready !== expGnt) begin
      testsFailed++;
      $display("[TB] FAIL rq_ready: got %b expected %b", rq_ready, expGnt);
    end
    if (expGnt == 2'b01) begin
      scoreQ.push_back(calc(1'b0, a0, b0));
      modelPrio = 1'b1;
    end else if (expGnt == 2'b10) begin
      scoreQ.push_back(calc(1'b1, a1, b1));
      modelPrio = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    @(negedge clk);
    #1;
    rq_valid  = 2'b00;
    rsp_ready = 1'b1;
    while ((scoreQ.size() != 0 || rsp_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if (scoreQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain_%s: got %0d responses outstanding expected 0", name, scoreQ.size());
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1;
    reset     = 1'b0;
    rq_valid  = 2'b00;
    rsp_ready = 1'b0;
    stat_clr  = 1'b0;
    scoreQ.delete();
    modelPrio = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    rq_valid = 2'b11;
    #2;
    testsRun++;
    if ({rq_ready, alu_a, alu_b, alu_ctrl, rsp_valid, stat_gnt0, stat_gnt1} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got rq_ready=%b alu_a=%h alu_b=%h ctrl=%b rsp_valid=%b gnt=%0d/%0d expected all 0",
               rq_ready, alu_a, alu_b, alu_ctrl, rsp_valid, stat_gnt0, stat_gnt1);
    end
    @(negedge clk);
    #1;
    reset    = 1'b1;
    rq_valid = 2'b00;
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0);
    applyStimulus(2'b11, 2'b10, 1'b0, 32'h0, 32'h0, 32'h33, 32'h44);
    applyStimulus(2'b11, 2'b01, 1'b0, 32'h55, 32'h66, 32'h77, 32'h88);
    @(negedge clk);
    #1;
    rq_valid = 2'b11;
    testsRun++;
    if (rsp_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_rsp_valid: got %b expected 1", rsp_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    testsRun++;
    if ({alu_a, alu_b, alu_ctrl} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_alu: got a=%h b=%h ctrl=%b expected 0", alu_a, alu_b, alu_ctrl);
    end
    testsRun++;
    if ({rq_ready, rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_ovf, rsp_branch, stat_gnt0, stat_gnt1} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_out: got rq_ready=%b rsp_valid=%b id=%b r=%h gnt=%0d/%0d expected 0",
               rq_ready, rsp_valid, rsp_id, rsp_r, stat_gnt0, stat_gnt1);
    end
    scoreQ.delete();
    modelPrio = 1'b0;
    @(negedge clk);
    #1;
    reset    = 1'b1;
    rq_valid = 2'b00;
    applyStimulus(2'b01, 2'b01, 1'b1, 32'd9, 32'd4, 32'd0, 32'd0);
    waitDrain("post_reset");
  endtask

  task automatic test_single();
    rq0_ctrl = 2'b10;
    applyStimulus(2'b01, 2'b01, 1'b0, 32'd5, 32'd3, 32'd100, 32'd200);
    @(negedge clk);
    #1;
    rq_valid = 2'b00;
    testsRun++;
    if ({alu_a, alu_b, alu_ctrl, rsp_valid} !== {32'd5, 32'd3, 2'b10, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL single_issue: got a=%0d b=%0d ctrl=%b rsp_valid=%b expected 5 3 10 0",
               alu_a, alu_b, alu_ctrl, rsp_valid);
    end
    @(negedge clk);
    #1;
    testsRun++;
    if ({rsp_valid, rsp_id, rsp_r, rsp_zero} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL single_rsp: got valid=%b id=%b r=%0d zero=%b expected 1 0 8 0",
               rsp_valid, rsp_id, rsp_r, rsp_zero);
    end
    waitDrain("single");
  endtask

  task automatic test_alternate();
    logic [1:0] expGnt;
    applyReset();
    for (int i = 0; i < 6; i++) begin
      expGnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      applyStimulus(2'b11, expGnt, 1'b1, WIDTH'(i * 100 + 1), WIDTH'(i), WIDTH'(i * 7 + 1000), 32'd3);
    end
    waitDrain("alternate");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      applyStimulus(2'b11, modelPrio ? 2'b10 : 2'b01, 1'b0,
                    WIDTH'(i + 40), WIDTH'(i * 3), WIDTH'(i + 500), WIDTH'(i * 11));
    end
    applyStimulus(2'b11, 2'b00, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
    applyStimulus(2'b11, 2'b00, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
    applyStimulus(2'b11, modelPrio ? 2'b10 : 2'b01, 1'b0, 32'd60, 32'd61, 32'd62, 32'd63);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
    waitDrain("backpressure");
  endtask

  task automatic test_overflow();
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    #1;
    rq_valid = 2'b00;
    #1;
    testsRun++;
    if ({rsp_id, rsp_r, rsp_zero, rsp_ovf} !== {1'b0, 32'h80000000, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL ovf_head: got id=%b r=%h zero=%b ovf=%b expected 0 80000000 0 1",
               rsp_id, rsp_r, rsp_zero, rsp_ovf);
    end
    applyStimulus(2'b00, 2'b00, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    #1;
    testsRun++;
    if ({rsp_id, rsp_r, rsp_zero, rsp_branch} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL zero_head: got id=%b r=%h zero=%b branch=%b expected 1 00000000 1 1",
               rsp_id, rsp_r, rsp_zero, rsp_branch);
    end
    waitDrain("overflow");
  endtask

  task automatic test_stats();
    logic [15:0] exp0, exp1;
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, 2'b01, 1'b1, WIDTH'(i), 32'd2, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++)  applyStimulus(2'b10, 2'b10, 1'b1, 32'd0, 32'd0, WIDTH'(i), 32'd5);
    @(negedge clk);
    #1;
    rq_valid = 2'b00;
    #1;
    exp0 = STATS_ON ? 16'd10 : 16'd0;
    exp1 = STATS_ON ? 16'd7 : 16'd0;
    testsRun++;
    if ({stat_gnt0, stat_gnt1} !== {exp0, exp1}) begin
      testsFailed++;
      $display("[TB] FAIL stat_count: got %0d/%0d expected %0d/%0d", stat_gnt0, stat_gnt1, exp0, exp1);
    end
    @(negedge clk);
    #1;
    stat_clr = 1'b1;
    rq_valid = 2'b01;
    rq0_a    = 32'd21;
    rq0_b    = 32'd21;
    #1;
    testsRun++;
    if (rq_ready !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL clr_cycle_ready: got %b expected 01", rq_ready);
    end
    scoreQ.push_back(calc(1'b0, 32'd21, 32'd21));
    @(negedge clk);
    #1;
    stat_clr = 1'b0;
    rq_valid = 2'b00;
    #1;
    testsRun++;
    if ({stat_gnt0, stat_gnt1} !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL stat_clr: got %0d/%0d expected 0/0", stat_gnt0, stat_gnt1);
    end
    applyStimulus(2'b01, 2'b01, 1'b1, 32'd1, 32'd1, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    rq_valid = 2'b00;
    #1;
    exp0 = STATS_ON ? 16'd1 : 16'd0;
    testsRun++;
    if ({stat_gnt0, stat_gnt1} !== {exp0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL stat_after_clr: got %0d/%0d expected %0d/0", stat_gnt0, stat_gnt1, exp0);
    end
    waitDrain("stats");
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    rq_valid  = 2'b00;
    rsp_ready = 1'b0;
    stat_clr  = 1'b0;
    rq0_a = '0; rq0_b = '0; rq1_a = '0; rq1_b = '0;
    rq0_ctrl = 2'b01;
    rq1_ctrl = 2'b11;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_overflow();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached after %0d tests, expected completion", testsRun);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single clocked `alu` between two requesters (fetch/branch-compare path and execute path) with valid/ready handshakes, round-robin arbitration and a tag pipeline matching ALU latency. Results, with flags and requester ID, go to a credit-protected response FIFO with its own valid/ready. Sits between requester front-ends and the `alu` instance; the block is the only driver of `A`, `B` and `CTRL`.

## Interface
- `WIDTH`, 32: operand/result width.
- `ALU_LAT`, 1: edges from ALU inputs changing to `R`/flags valid for sampling; legal 1..4.
- `FIFO_DEPTH`, 4: response FIFO entries; power of two, ≥ `ALU_LAT`+1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `rq_valid[1:0]` in 2: per-requester request valid.
- `rq_ready[1:0]` out 2: per-requester accept; at most one bit high.
- `rq0_a`, `rq0_b`, `rq1_a`, `rq1_b` in WIDTH: operands.
- `rq0_ctrl`, `rq1_ctrl` in 2: ALU operation code.
- `alu_a`, `alu_b` out WIDTH; `alu_ctrl` out 2: registered ALU inputs.
- `alu_r` in WIDTH; `alu_zero`, `alu_ovf`, `alu_branch` in 1: ALU outputs.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_id` out 1; `rsp_r` out WIDTH; `rsp_zero`, `rsp_ovf`, `rsp_branch` out 1.
- `stat_clr` in 1; `stat_gnt0`, `stat_gnt1` out 16: grant counters (see Configuration).

## Operation
- Reset (async assert, sync release): `alu_a`/`alu_b`/`alu_ctrl` = 0, tag pipeline invalid, FIFO empty, `rsp_valid`=0, `rq_ready`=0, RR pointer favours requester 0, counters 0. In-flight operations are discarded.
- Credit: `can_issue` = (fifo_count + inflight) < `FIFO_DEPTH`; a same-cycle pop is not credited.
- Arbitration (combinational): with `can_issue`, one valid requester is granted; both valid → the one not granted last. `rq_ready[i]` = grant[i]; it may depend on `rq_valid`, and requesters must not make valid depend on ready.
- Accept = `rq_valid[i] & rq_ready[i]`: operands/ctrl are registered onto `alu_*`; tag {valid, id} enters stage 0; RR pointer updates. Without accept, `alu_*` hold their values and a 0-valid tag enters.
- Tag pipeline: `ALU_LAT` stages; a valid tag at the last stage pushes {id, `alu_r`, zero, ovf, branch} into the FIFO on that edge.
- FIFO: show-ahead; `rsp_*` reflect the head; pop on `rsp_valid & rsp_ready`. Simultaneous push and pop are legal at any count. Credit prevents overflow; a push into a full FIFO is an assertion failure.
- Operands and results pass through unmodified; ordering is global issue order.

## Timing
- Accept at edge k → `alu_*` valid after k → FIFO write at edge k+`ALU_LAT` → `rsp_valid` high in the following cycle (latency `ALU_LAT`+1 cycles) if the FIFO was empty.
- With `FIFO_DEPTH` ≥ `ALU_LAT`+2 and `rsp_ready` held high: one accept per cycle sustained.
- `rsp_ready` low: accepts continue until count+inflight = `FIFO_DEPTH`, then `rq_ready`=0 until the first pop edge.

## Configuration
- `ALU_ARB_STATS_EN` defined: `stat_gnt0`/`stat_gnt1` count accepts per requester, 16-bit, saturating at 0xFFFF. `stat_clr` zeroes them synchronously and takes priority over a same-cycle increment.
- `ALU_ARB_STATS_EN` undefined: ports remain, outputs tied to 0, `stat_clr` ignored, no counter flops.

## Structure
- Package `alu_arb_pkg`: `ALU_CTRL_W`=2, `alu_arb_tag_t` {valid, id}, `alu_arb_rsp_t` {id, r, zero, ovf, branch}, `STAT_W`=16.
- Sub-module `alu_arb_fifo`: parameterised sync FIFO (depth, payload width), show-ahead, count output.
- Top holds the arbiter, RR pointer, ALU input registers, tag shift register and credit logic.

## Test plan
Bench uses a behavioural ALU stub: `R`=A+B registered with `ALU_LAT`, zero=(R==0), ovf=signed overflow, branch=zero.
- Reset mid-stream with 3 in flight → all outputs 0 asynchronously; after release, the first request from req0 gives a response with id=0.
- Only req0 valid, a=5, b=3 → `rq_ready`=01 in the same cycle; `rsp_valid` 2 cycles after accept with r=8, zero=0, id=0.
- Both valid for 6 cycles → accepts alternate 0,1,0,1,0,1; responses appear in the same order.
- `rsp_ready`=0, both valid, default params → exactly 4 accepts then `rq_ready`=00; one pop restores one accept the next cycle.
- a=0x7FFFFFFF, b=1 → r=0x80000000, ovf=1; a=0xFFFFFFFF, b=1 → r=0, zero=1, branch=1.
- With `ALU_ARB_STATS_EN`: 10 req0 accepts and 7 req1 accepts → counters 10/7; `stat_clr` → 0/0. Without the macro → 0/0 throughout.
